uart_tx_ram_reader: RTL



---
 rtl/uart_tx_ram_reader_if.sv | 25 ++
 rtl/uart_tx_ram_reader.sv | 111 +++++++++++
 2 files changed

// File: rtl/uart_tx_ram_reader_if.sv
// Signals between the UART transmit reader, its dual-clock RAM read port and the writer side.
// The master modport is the reader's view.
interface uart_tx_ram_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic [ADDR_WIDTH:0]   write_ptr;
  logic                  tx_enable;
  logic [DATA_WIDTH-1:0] q;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [ADDR_WIDTH:0]   read_ptr;
  logic                  tx;
  logic                  busy;
  logic                  empty;

  modport master (
    input  write_ptr, tx_enable, q,
    output read_addr, read_ptr, tx, busy, empty
  );

  modport slave (
    output write_ptr, tx_enable, q,
    input  read_addr, read_ptr, tx, busy, empty
  );
endinterface

// File: rtl/uart_tx_ram_reader.sv
// Drains the transmit-buffer RAM in the UART clock domain and sends each byte as an 8N1 frame.
// The read pointer advances once per frame and is exported for the writer's full check.
module uart_tx_ram_reader #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 3,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  uart_tx_ram_reader_if.master bus
);
  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic                  tx_q, tx_d;
  logic                  empty;
  logic                  start_ok;
  logic                  baud_done;

  assign empty     = (bus.write_ptr == rptr_q);
  assign start_ok  = bus.tx_enable && !empty;
  assign baud_done = (cnt_q == CNT_LAST);

  assign bus.read_addr = rptr_q[ADDR_WIDTH-1:0];
  assign bus.read_ptr  = rptr_q;
  assign bus.tx        = tx_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.empty     = empty;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rptr_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rptr_q  <= rptr_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    rptr_d  = rptr_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_ok) state_d = FETCH;
      end
      // The RAM registered read_addr on the edge that entered FETCH, so q is valid now.
      FETCH: begin
        cnt_d   = '0;
        shift_d = bus.q;
        rptr_d  = rptr_q + PTR_W'(1);
        state_d = START;
      end
      START: begin
        if (baud_done) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) state_d = STOP;
          else                   bit_d   = bit_q + BIT_W'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          cnt_d   = '0;
          state_d = start_ok ? FETCH : IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // tx is registered from the next state so each level starts right after its entry edge.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end
endmodule
